// File: rtl/onehot_demux_pkg.sv
// Shared defaults and select-legality helper for the one-hot result demultiplexer.
package onehot_demux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_N     = 8;

  // A select is legal only when exactly one bit is set; callers zero-extend to MAX_N.
  function automatic logic onehot_legal(input logic [MAX_N-1:0] sel);
    return (sel != '0) && ((sel & (sel - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry valid/ready output register; a drain and a load may happen in the same cycle.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             can_accept_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = load_i | (full_q & ~ready_i);
    data_d = load_i ? din_i : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o       = full_q;
  assign dout_o       = data_q;
  assign can_accept_o = ~full_q | ready_i;

endmodule

// File: rtl/onehot_demux_reg.sv
// Registered 1-to-N demultiplexer: routes a result beat to the channel named by a one-hot select,
// dropping and counting beats whose select is not one-hot.
module onehot_demux_reg
  import onehot_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [N-1:0]       in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               err_sel,
  output logic [CNT_W-1:0]   drop_cnt,
  input  logic               err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_N-1:0] sel_ext;
  logic             legal;
  logic             accept;
  logic             drop;
  logic [N-1:0]     load;
  logic [N-1:0]     can_accept;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sel_ext        = '0;
    sel_ext[N-1:0] = in_sel;
  end

  assign legal = onehot_legal(sel_ext);

  // Illegal beats are always taken so the drop path never stalls the producer.
  assign in_ready = legal ? |(in_sel & can_accept) : 1'b1;
  assign accept   = in_valid & in_ready;
  assign load     = {N{accept & legal}} & in_sel;
  assign drop     = accept & ~legal;

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load[k]),
      .din_i        (in_data),
      .ready_i      (out_ready[k]),
      .full_o       (out_valid[k]),
      .dout_o       (out_data[k*WIDTH +: WIDTH]),
      .can_accept_o (can_accept[k])
    );
  end

  // A drop coincident with a clear wins: the counter restarts at one.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (drop) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_onehot_demux_reg.sv
// Directed bench for onehot_demux_reg: a per-channel slot model checked every cycle, plus literal checkpoints.
module tb_onehot_demux_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int DW    = N * WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [N-1:0]     in_sel;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [DW-1:0]    out_data;
  logic             err_sel;
  logic [CNT_W-1:0] drop_cnt;
  logic             err_clr;

  int total = 0;
  int bad   = 0;

  onehot_demux_reg #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_sel   (err_sel),
    .drop_cnt  (drop_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each channel is a one-deep box; the error side is a flag and a saturating tally.
  bit               m_full [N];
  logic [WIDTH-1:0] m_data [N];
  bit               m_err;
  int               m_cnt;

  function automatic int sel_index(input logic [N-1:0] s);
    int idx = -1;
    for (int j = 0; j < N; j++) if (s[j]) idx = j;
    return idx;
  endfunction

  function automatic bit m_in_ready();
    if ($countones(in_sel) != 1) return 1'b1;
    return !m_full[sel_index(in_sel)] || out_ready[sel_index(in_sel)];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        m_full[j] = 1'b0;
        m_data[j] = '0;
      end
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      bit take;
      bit dropped;
      int k;
      k       = sel_index(in_sel);
      take    = in_valid && ($countones(in_sel) == 1) && m_in_ready();
      dropped = in_valid && ($countones(in_sel) != 1);
      for (int j = 0; j < N; j++) begin
        if (take && j == k) begin
          m_full[j] = 1'b1;
          m_data[j] = in_data;
        end else if (m_full[j] && out_ready[j]) begin
          m_full[j] = 1'b0;
        end
      end
      if (err_clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
      if (dropped) begin
        m_err = 1'b1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    for (int j = 0; j < N; j++) begin
      ev[j]                 = m_full[j];
      ed[j*WIDTH +: WIDTH]  = m_data[j];
    end
    chk("model_in_ready", DW'(in_ready), DW'(m_in_ready()));
    chk("model_out_valid", DW'(out_valid), DW'(ev));
    chk("model_out_data", out_data, ed);
    chk("model_err_sel", DW'(err_sel), DW'(m_err));
    chk("model_drop_cnt", DW'(drop_cnt), DW'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 4'b0010;
    in_data   = 32'hAA;
    out_ready = 4'b0000;
    err_clr   = 1'b0;

    // Reset holds everything empty even with a valid beat presented.
    repeat (3) step();
    chk("rst_out_valid", DW'(out_valid), DW'(4'b0000));
    chk("rst_out_data", out_data, '0);
    chk("rst_err_sel", DW'(err_sel), DW'(1'b0));
    chk("rst_drop_cnt", DW'(drop_cnt), DW'(8'd0));
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rel_capture_valid", DW'(out_valid), DW'(4'b0010));
    chk("rel_capture_data", DW'(out_data[63:32]), DW'(32'hAA));
    out_ready = 4'b1111;
    step();
    chk("rel_drain", DW'(out_valid), DW'(4'b0000));

    // Single route to channel 2.
    in_valid = 1'b1; in_sel = 4'b0100; in_data = 32'hDEADBEEF;
    #1 chk("route_in_ready", DW'(in_ready), DW'(1'b1));
    step();
    in_valid = 1'b0;
    chk("route_valid", DW'(out_valid), DW'(4'b0100));
    chk("route_data", DW'(out_data[95:64]), DW'(32'hDEADBEEF));
    step();
    chk("route_clear", DW'(out_valid), DW'(4'b0000));

    // Back-pressure on channel 0.
    out_ready = 4'b1110;
    in_valid = 1'b1; in_sel = 4'b0001; in_data = 32'h11;
    step();
    in_data = 32'h22;
    #1 chk("bp_stall_ready", DW'(in_ready), DW'(1'b0));
    step();
    chk("bp_hold_data", DW'(out_data[31:0]), DW'(32'h11));
    step();
    chk("bp_hold_data2", DW'(out_data[31:0]), DW'(32'h11));
    in_sel = 4'b1000; in_data = 32'h33;
    #1 chk("bp_other_ready", DW'(in_ready), DW'(1'b1));
    step();
    chk("bp_other_valid", DW'(out_valid), DW'(4'b1001));
    in_sel = 4'b0001; in_data = 32'h22; out_ready = 4'b1111;
    #1 chk("bp_release_ready", DW'(in_ready), DW'(1'b1));
    step();
    in_valid = 1'b0;
    chk("bp_swap_valid", DW'(out_valid), DW'(4'b0001));
    chk("bp_swap_data", DW'(out_data[31:0]), DW'(32'h22));
    step();

    // Streaming eight beats through channel 1.
    in_sel = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      #1 chk("stream_ready", DW'(in_ready), DW'(1'b1));
      step();
      chk("stream_data", DW'(out_data[63:32]), DW'(i));
      chk("stream_valid", DW'(out_valid), DW'(4'b0010));
    end
    in_valid = 1'b0;
    step();

    // Illegal selects are swallowed and counted.
    in_valid = 1'b1; in_sel = 4'b0000;
    #1 chk("ill_zero_ready", DW'(in_ready), DW'(1'b1));
    step();
    in_sel = 4'b0110;
    #1 chk("ill_multi_ready", DW'(in_ready), DW'(1'b1));
    step();
    in_valid = 1'b0;
    chk("ill_err", DW'(err_sel), DW'(1'b1));
    chk("ill_cnt", DW'(drop_cnt), DW'(8'd2));
    chk("ill_no_valid", DW'(out_valid), DW'(4'b0000));
    in_valid = 1'b1; in_sel = 4'b0000; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("clr_race_cnt", DW'(drop_cnt), DW'(8'd1));
    chk("clr_race_err", DW'(err_sel), DW'(1'b1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_cnt", DW'(drop_cnt), DW'(8'd0));
    chk("clr_err", DW'(err_sel), DW'(1'b0));

    // Saturation of the drop counter.
    in_valid = 1'b1; in_sel = 4'b1111;
    repeat (300) step();
    chk("sat_cnt", DW'(drop_cnt), DW'(8'd255));
    repeat (2) step();
    chk("sat_hold", DW'(drop_cnt), DW'(8'd255));
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sat_clr_cnt", DW'(drop_cnt), DW'(8'd0));
    chk("sat_clr_err", DW'(err_sel), DW'(1'b0));

    // Asynchronous reset discards a stalled slot at once.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 4'b0100; in_data = 32'h5A5A5A5A;
    step();
    in_valid = 1'b0;
    chk("mid_loaded", DW'(out_valid), DW'(4'b0100));
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", DW'(out_valid), DW'(4'b0000));
    chk("mid_rst_data", out_data, '0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
